// File: rtl/plotter_cmd_parser.sv
// ASCII command parser: opcode letter + optional decimal argument -> command word, plus 7-seg char code.
// Optional: define CMD_CASE_FOLD_EN to accept uppercase F/R/L/U/D as their lowercase commands.
module plotter_cmd_parser #(
    parameter int ARG_W      = 16,
    parameter int MAX_DIGITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic [7:0]       cmd_op,
    output logic [ARG_W-1:0] cmd_arg,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [7:0]       disp_char,
    output logic             err
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARG,
        S_HOLD,
        S_ERR
    } state_t;

    typedef enum logic [2:0] {
        C_LETTER,
        C_DIGIT,
        C_TERM,
        C_SPACE,
        C_OTHER
    } cls_t;

    state_t           state, state_n;
    logic [7:0]       opcode, opcode_n;
    logic [ARG_W-1:0] acc, acc_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [7:0]       cmd_op_n;
    logic [ARG_W-1:0] cmd_arg_n;
    logic             cmd_valid_n;
    logic [7:0]       disp_n;
    logic             err_n;

    cls_t             cls;
    logic [7:0]       folded;
    logic             take;
    logic             arg_op;
    logic             room;
    logic [ARG_W-1:0] acc_step;

    // Byte classification; folded is the byte as it should be latched/displayed
    always_comb begin
        cls    = C_OTHER;
        folded = rx_data;
        case (rx_data)
            8'd102, 8'd114, 8'd108, 8'd117, 8'd100: cls = C_LETTER;
            8'd10, 8'd13, 8'd59:                    cls = C_TERM;
            8'd32:                                  cls = C_SPACE;
`ifdef CMD_CASE_FOLD_EN
            8'd70, 8'd82, 8'd76, 8'd85, 8'd68: begin
                cls    = C_LETTER;
                folded = rx_data | 8'h20;
            end
`endif
            default: begin
                if (rx_data >= 8'd48 && rx_data <= 8'd57) begin
                    cls = C_DIGIT;
                end
            end
        endcase
    end

    assign rx_ready = (state != S_HOLD);
    assign take     = rx_valid && rx_ready;
    assign arg_op   = (opcode == 8'd102) || (opcode == 8'd114) || (opcode == 8'd108);
    assign room     = (cnt < CNT_W'(MAX_DIGITS));
    // acc*10 + digit, wrapping at ARG_W; the low nibble of an ASCII digit is its value
    assign acc_step = (acc << 3) + (acc << 1) + ARG_W'(rx_data[3:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            opcode    <= '0;
            acc       <= '0;
            cnt       <= '0;
            cmd_op    <= '0;
            cmd_arg   <= '0;
            cmd_valid <= 1'b0;
            disp_char <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            opcode    <= opcode_n;
            acc       <= acc_n;
            cnt       <= cnt_n;
            cmd_op    <= cmd_op_n;
            cmd_arg   <= cmd_arg_n;
            cmd_valid <= cmd_valid_n;
            disp_char <= disp_n;
            err       <= err_n;
        end
    end

    always_comb begin
        state_n     = state;
        opcode_n    = opcode;
        acc_n       = acc;
        cnt_n       = cnt;
        cmd_op_n    = cmd_op;
        cmd_arg_n   = cmd_arg;
        cmd_valid_n = cmd_valid;
        disp_n      = disp_char;
        err_n       = 1'b0;

        // take is never true in HOLD, so the display is frozen there
        if (take) begin
            case (cls)
                C_LETTER: disp_n = folded;
                C_DIGIT:  disp_n = {4'd0, rx_data[3:0]};
                C_OTHER:  disp_n = rx_data;
                default:  disp_n = disp_char;
            endcase
        end

        case (state)
            S_IDLE: begin
                if (take) begin
                    case (cls)
                        C_LETTER: begin
                            opcode_n = folded;
                            acc_n    = '0;
                            cnt_n    = '0;
                            state_n  = S_ARG;
                        end
                        C_DIGIT, C_OTHER: begin
                            err_n   = 1'b1;
                            state_n = S_ERR;
                        end
                        default: state_n = S_IDLE;
                    endcase
                end
            end
            S_ARG: begin
                if (take) begin
                    case (cls)
                        C_DIGIT: begin
                            if (arg_op && room) begin
                                acc_n = acc_step;
                                cnt_n = cnt + 1'b1;
                            end else begin
                                err_n   = 1'b1;
                                state_n = S_ERR;
                            end
                        end
                        C_TERM: begin
                            cmd_op_n    = opcode;
                            cmd_arg_n   = acc;
                            cmd_valid_n = 1'b1;
                            state_n     = S_HOLD;
                        end
                        C_SPACE: state_n = S_ARG;
                        default: begin
                            err_n   = 1'b1;
                            state_n = S_ERR;
                        end
                    endcase
                end
            end
            S_HOLD: begin
                if (cmd_ready) begin
                    cmd_valid_n = 1'b0;
                    state_n     = S_IDLE;
                end
            end
            S_ERR: begin
                if (take && cls == C_TERM) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_plotter_cmd_parser.sv
// Directed self-checking bench for plotter_cmd_parser (default ARG_W=16, MAX_DIGITS=4).
module tb_plotter_cmd_parser;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  cmd_op;
    logic [15:0] cmd_arg;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  disp_char;
    logic        err;

    int n_cmp;
    int n_bad;
    int err_count;
    int valid_count;

    plotter_cmd_parser #(.ARG_W(16), .MAX_DIGITS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .disp_char (disp_char),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err === 1'b1) err_count++;
        if (cmd_valid === 1'b1) valid_count++;
    end

    // Present one byte; returns #1 after the edge that consumed it
    task automatic send_byte(input logic [7:0] b);
        int unsigned n;
        n = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (rx_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL send_timeout byte=%0d rx_ready=%b required 1", b, rx_ready);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'd0;
        cmd_ready = 1'b1;
        idle(2);
        n_cmp++;
        if ({cmd_op, cmd_arg, cmd_valid, disp_char, err, rx_ready} !== {8'd0, 16'd0, 1'b0, 8'd0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_state op=%0d arg=%0d v=%b disp=%0d err=%b rdy=%b required 0/0/0/0/0/1",
                     cmd_op, cmd_arg, cmd_valid, disp_char, err, rx_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_basic;
        int e0, v0;
        e0 = err_count;
        v0 = valid_count;
        cmd_ready = 1'b1;
        send_byte(8'd102);
        n_cmp++;
        if (disp_char !== 8'd102) begin n_bad++; $display("FAIL basic_disp_f got=%0d required 102", disp_char); end
        send_byte(8'd49);
        n_cmp++;
        if (disp_char !== 8'd1) begin n_bad++; $display("FAIL basic_disp_1 got=%0d required 1", disp_char); end
        send_byte(8'd50);
        n_cmp++;
        if (disp_char !== 8'd2) begin n_bad++; $display("FAIL basic_disp_2 got=%0d required 2", disp_char); end
        send_byte(8'd48);
        n_cmp++;
        if (disp_char !== 8'd0) begin n_bad++; $display("FAIL basic_disp_0 got=%0d required 0", disp_char); end
        send_byte(8'd10);
        n_cmp++;
        if ({cmd_valid, cmd_op, cmd_arg} !== {1'b1, 8'd102, 16'd120}) begin
            n_bad++;
            $display("FAIL basic_cmd v=%b op=%0d arg=%0d required 1/102/120", cmd_valid, cmd_op, cmd_arg);
        end
        idle(1);
        n_cmp++;
        if (cmd_valid !== 1'b0 || rx_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_release v=%b rdy=%b required 0/1", cmd_valid, rx_ready);
        end
        n_cmp++;
        if (valid_count - v0 != 1 || err_count != e0) begin
            n_bad++;
            $display("FAIL basic_counts valid_cycles=%0d errs=%0d required 1/0", valid_count - v0, err_count - e0);
        end
    endtask

    task automatic test_hold;
        cmd_ready = 1'b0;
        send_byte(8'd114);
        send_byte(8'd32);
        send_byte(8'd55);
        send_byte(8'd59);
        n_cmp++;
        if ({cmd_valid, cmd_op, cmd_arg, rx_ready} !== {1'b1, 8'd114, 16'd7, 1'b0}) begin
            n_bad++;
            $display("FAIL hold_cmd v=%b op=%0d arg=%0d rdy=%b required 1/114/7/0", cmd_valid, cmd_op, cmd_arg, rx_ready);
        end
        rx_data  = 8'd117;
        rx_valid = 1'b1;
        for (int unsigned i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({rx_ready, cmd_valid, cmd_op, cmd_arg, disp_char} !== {1'b0, 1'b1, 8'd114, 16'd7, 8'd7}) begin
                n_bad++;
                $display("FAIL hold_stable cyc=%0d rdy=%b v=%b op=%0d arg=%0d disp=%0d required 0/1/114/7/7",
                         i, rx_ready, cmd_valid, cmd_op, cmd_arg, disp_char);
            end
        end
        @(negedge clk);
        cmd_ready = 1'b1;
        @(posedge clk);
        #1;
        cmd_ready = 1'b0;
        n_cmp++;
        if ({cmd_valid, rx_ready, disp_char} !== {1'b0, 1'b1, 8'd7}) begin
            n_bad++;
            $display("FAIL hold_handshake v=%b rdy=%b disp=%0d required 0/1/7", cmd_valid, rx_ready, disp_char);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        n_cmp++;
        if (disp_char !== 8'd117) begin n_bad++; $display("FAIL hold_u_taken disp=%0d required 117", disp_char); end
        send_byte(8'd13);
        n_cmp++;
        if ({cmd_valid, cmd_op, cmd_arg} !== {1'b1, 8'd117, 16'd0}) begin
            n_bad++;
            $display("FAIL hold_u_cmd v=%b op=%0d arg=%0d required 1/117/0", cmd_valid, cmd_op, cmd_arg);
        end
        cmd_ready = 1'b1;
        idle(2);
    endtask

    task automatic test_max_digits;
        logic [7:0] s [6];
        int e0;
        s = '{8'd108, 8'd49, 8'd50, 8'd51, 8'd52, 8'd53};
        e0 = err_count;
        cmd_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_byte(s[i]);
            n_cmp++;
            if (err !== (i == 5)) begin
                n_bad++;
                $display("FAIL maxdig_err idx=%0d err=%b required %b", i, err, (i == 5));
            end
        end
        send_byte(8'd10);
        n_cmp++;
        if (cmd_valid !== 1'b0 || err_count - e0 != 1) begin
            n_bad++;
            $display("FAIL maxdig_nocmd v=%b errs=%0d required 0/1", cmd_valid, err_count - e0);
        end
        send_byte(8'd100);
        send_byte(8'd10);
        n_cmp++;
        if ({cmd_valid, cmd_op, cmd_arg} !== {1'b1, 8'd100, 16'd0}) begin
            n_bad++;
            $display("FAIL maxdig_d v=%b op=%0d arg=%0d required 1/100/0", cmd_valid, cmd_op, cmd_arg);
        end
        idle(1);
        send_byte(8'd102);
        send_byte(8'd57);
        send_byte(8'd57);
        send_byte(8'd57);
        send_byte(8'd57);
        send_byte(8'd59);
        n_cmp++;
        if ({cmd_valid, cmd_op, cmd_arg} !== {1'b1, 8'd102, 16'd9999}) begin
            n_bad++;
            $display("FAIL maxdig_9999 v=%b op=%0d arg=%0d required 1/102/9999", cmd_valid, cmd_op, cmd_arg);
        end
        idle(1);
    endtask

    task automatic test_errors;
        int e0, v0;
        e0 = err_count;
        v0 = valid_count;
        cmd_ready = 1'b1;
        send_byte(8'd100);
        send_byte(8'd53);
        n_cmp++;
        if (err !== 1'b1 || disp_char !== 8'd5) begin
            n_bad++;
            $display("FAIL err_d5 err=%b disp=%0d required 1/5", err, disp_char);
        end
        send_byte(8'd10);
        send_byte(8'd120);
        n_cmp++;
        if (err !== 1'b1 || disp_char !== 8'd120) begin
            n_bad++;
            $display("FAIL err_x err=%b disp=%0d required 1/120", err, disp_char);
        end
        send_byte(8'd10);
        send_byte(8'd55);
        n_cmp++;
        if (err !== 1'b1 || disp_char !== 8'd7) begin
            n_bad++;
            $display("FAIL err_7 err=%b disp=%0d required 1/7", err, disp_char);
        end
        send_byte(8'd10);
        idle(1);
        n_cmp++;
        if (err_count - e0 != 3 || valid_count != v0) begin
            n_bad++;
            $display("FAIL err_counts errs=%0d cmds=%0d required 3/0", err_count - e0, valid_count - v0);
        end
    endtask

    task automatic test_back_to_back;
        cmd_ready = 1'b1;
        send_byte(8'd102);
        send_byte(8'd49);
        send_byte(8'd59);
        n_cmp++;
        if ({cmd_valid, cmd_op, cmd_arg} !== {1'b1, 8'd102, 16'd1}) begin
            n_bad++;
            $display("FAIL b2b_first v=%b op=%0d arg=%0d required 1/102/1", cmd_valid, cmd_op, cmd_arg);
        end
        send_byte(8'd114);
        send_byte(8'd50);
        send_byte(8'd59);
        n_cmp++;
        if ({cmd_valid, cmd_op, cmd_arg} !== {1'b1, 8'd114, 16'd2}) begin
            n_bad++;
            $display("FAIL b2b_second v=%b op=%0d arg=%0d required 1/114/2", cmd_valid, cmd_op, cmd_arg);
        end
        idle(1);
    endtask

    task automatic test_reset_in_hold;
        cmd_ready = 1'b0;
        send_byte(8'd102);
        send_byte(8'd57);
        send_byte(8'd10);
        n_cmp++;
        if (cmd_valid !== 1'b1 || cmd_arg !== 16'd9) begin
            n_bad++;
            $display("FAIL rsthold_pre v=%b arg=%0d required 1/9", cmd_valid, cmd_arg);
        end
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({cmd_valid, disp_char, rx_ready} !== {1'b0, 8'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL rsthold_async v=%b disp=%0d rdy=%b required 0/0/1", cmd_valid, disp_char, rx_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        cmd_ready = 1'b1;
        send_byte(8'd102);
        send_byte(8'd51);
        send_byte(8'd10);
        n_cmp++;
        if ({cmd_valid, cmd_op, cmd_arg} !== {1'b1, 8'd102, 16'd3}) begin
            n_bad++;
            $display("FAIL rsthold_after v=%b op=%0d arg=%0d required 1/102/3", cmd_valid, cmd_op, cmd_arg);
        end
        idle(1);
    endtask

    task automatic test_case_fold;
        int e0, v0;
        e0 = err_count;
        v0 = valid_count;
        cmd_ready = 1'b1;
        send_byte(8'd70);
`ifdef CMD_CASE_FOLD_EN
        n_cmp++;
        if (err !== 1'b0 || disp_char !== 8'd102) begin
            n_bad++;
            $display("FAIL fold_F err=%b disp=%0d required 0/102", err, disp_char);
        end
        send_byte(8'd52);
        send_byte(8'd50);
        send_byte(8'd10);
        n_cmp++;
        if ({cmd_valid, cmd_op, cmd_arg} !== {1'b1, 8'd102, 16'd42}) begin
            n_bad++;
            $display("FAIL fold_cmd v=%b op=%0d arg=%0d required 1/102/42", cmd_valid, cmd_op, cmd_arg);
        end
        idle(1);
`else
        n_cmp++;
        if (err !== 1'b1 || disp_char !== 8'd70) begin
            n_bad++;
            $display("FAIL nofold_F err=%b disp=%0d required 1/70", err, disp_char);
        end
        send_byte(8'd52);
        send_byte(8'd50);
        send_byte(8'd10);
        idle(1);
        n_cmp++;
        if (err_count - e0 != 1 || valid_count != v0 || disp_char !== 8'd2) begin
            n_bad++;
            $display("FAIL nofold_after errs=%0d cmds=%0d disp=%0d required 1/0/2",
                     err_count - e0, valid_count - v0, disp_char);
        end
`endif
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        err_count   = 0;
        valid_count = 0;
        test_reset;
        test_basic;
        test_hold;
        test_max_digits;
        test_errors;
        test_back_to_back;
        test_reset_in_hold;
        test_case_fold;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/plotter_cmd_parser.md
Name: plotter_cmd_parser

Overview:
Byte-stream command parser for the plotter front end. It sits between the serial byte receiver and the motion sequencer. It assembles ASCII commands (opcode letter plus optional decimal argument) into one validated command word with a ready/valid handshake. It also drives the 8-bit character code consumed by the 7-segment character decoder: command letters are passed as ASCII, digits as values 0-9, and anything else as the raw byte, which the decoder shows as "E".

Parameters:
ARG_W, 16, width of the decoded numeric argument
MAX_DIGITS, 4, maximum decimal digits per argument; must satisfy 10^MAX_DIGITS-1 < 2^ARG_W

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
rx_data  input  8  received ASCII byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  parser can accept a byte; byte consumed when rx_valid && rx_ready at a rising edge
cmd_op  output  8  ASCII opcode of the completed command: 102 f, 114 r, 108 l, 117 u, 100 d
cmd_arg  output  ARG_W  decimal argument, binary
cmd_valid  output  1  command available; held until accepted
cmd_ready  input  1  downstream accepts command when cmd_valid && cmd_ready
disp_char  output  8  character code for the 7-segment decoder
err  output  1  one-cycle pulse on a parse error

Behaviour:
- Reset (async assert, sync release):
  - state IDLE; cmd_op=0, cmd_arg=0, cmd_valid=0, disp_char=0 (decoder shows "0"), err=0.
  - Digit counter=0, argument accumulator=0.
- rx_ready = (state != HOLD). Combinational, no bubble.
- Byte classes:
  - LETTER: 102, 114, 108, 117, 100.
  - DIGIT: 48-57.
  - TERM: 10, 13, 59 (';').
  - SPACE: 32.
  - OTHER: all remaining bytes.
- IDLE:
  - LETTER: latch opcode, clear accumulator and digit count, go to ARG.
  - TERM/SPACE: ignored, stay in IDLE.
  - DIGIT/OTHER: err pulse, go to ERR.
- ARG:
  - DIGIT with opcode f/r/l and count < MAX_DIGITS: acc <= acc*10 + (byte-48), truncated to ARG_W; count+1.
  - DIGIT with opcode u/d, or count == MAX_DIGITS: err pulse, go to ERR.
  - SPACE: ignored.
  - TERM: cmd_op <= opcode, cmd_arg <= acc (0 if no digits), cmd_valid <= 1, go to HOLD.
  - LETTER/OTHER: err pulse, go to ERR. The partial command is discarded.
- HOLD:
  - rx_ready=0, so no bytes are consumed.
  - On cmd_ready: cmd_valid <= 0, go to IDLE. rx_ready returns to 1 in the following cycle.
  - cmd_op and cmd_arg stay stable while cmd_valid=1. After the handshake they hold their last values.
- ERR: discard all bytes until TERM, then go to IDLE. No cmd_valid is produced.
- Latency:
  - TERM consumed at edge N: cmd_valid=1 after edge N.
  - With cmd_ready tied high, cmd_valid is high for exactly one cycle.
- disp_char updates on the edge a byte is consumed, in any state except HOLD:
  - LETTER: the byte itself.
  - DIGIT: byte-48.
  - OTHER: the byte itself.
  - TERM/SPACE: no change.
- err is a single-cycle pulse, registered on the consuming edge. It does not repeat while in ERR.
- Reset mid-command or in HOLD: cmd_valid drops immediately and the partial command is lost.

Optional Feature:
CMD_CASE_FOLD_EN
- Defined: uppercase 70, 82, 76, 85, 68 ('F','R','L','U','D') are classed as LETTER and folded to lowercase. Folding applies to the latched opcode and to disp_char.
- Undefined: these bytes are OTHER: err pulse, ERR state, disp_char = raw byte.

Test Plan:
- "f120\n" with cmd_ready=1 -> cmd_valid one cycle, cmd_op=102, cmd_arg=120; disp_char sequence 102, 1, 2, 0; err never.
- "r 7;" then "u\r" with cmd_ready=0 for 5 cycles -> first command r/7 held with rx_ready=0; the 'u' byte is not consumed until the handshake; then u/0 is issued.
- "l12345\n" with MAX_DIGITS=4 -> err pulse on '5'; no cmd_valid; the next "d\n" yields d/0.
- "d5\n", "x\n", "7\n" -> err pulse for each line; disp_char=120 after 'x'; no commands issued.
- Reset asserted in HOLD after "f9\n" -> cmd_valid=0 and disp_char=0 asynchronously; a subsequent "f3\n" yields f/3.
- "F42\n" -> with CMD_CASE_FOLD_EN: cmd_op=102, cmd_arg=42. Without it: err pulse, disp_char=70, no command.
